// File: rtl/data_memory_responder.sv
// Shared word-addressed data RAM serving NUM_CORES load/store ports.
// Round-robin arbitration; one access at a time, fixed 2-cycle latency, registered read data and ready pulse.
module data_memory_responder #(
    parameter int NUM_CORES = 2,
    parameter int DEPTH     = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CORES-1:0]      MEMREAD,
    input  logic [NUM_CORES-1:0]      MEMWR,
    input  logic [16*NUM_CORES-1:0]   DMADDR,
    input  logic [16*NUM_CORES-1:0]   DOUT,
    output logic [16*NUM_CORES-1:0]   DIN,
    output logic [NUM_CORES-1:0]      MEMRDY
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              GW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [16:0]     DEPTH_LIM = 17'(DEPTH);
    localparam logic [GW-1:0]   LAST_RST = GW'(NUM_CORES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                   state_q, state_d;
    logic [GW-1:0]            grant_q, grant_d;
    logic [GW-1:0]            last_q, last_d;
    logic [15:0]              addr_q, addr_d;
    logic [15:0]              wdata_q, wdata_d;
    logic                     wr_q, wr_d;
    logic [16*NUM_CORES-1:0]  din_q, din_d;
    logic [NUM_CORES-1:0]     rdy_q, rdy_d;

    logic [15:0]              mem [DEPTH];

    logic [NUM_CORES-1:0]     req;
    logic                     found;
    logic [GW-1:0]            pick;
    logic [GW-1:0]            cand_idx;
    int                       cand;
    logic [15:0]              sel_addr;
    logic [15:0]              sel_data;
    logic                     sel_wr;
    logic                     in_range;
    logic [AW-1:0]            mem_idx;
    logic [15:0]              rd_data;

    assign req      = MEMREAD | MEMWR;
    assign in_range = {1'b0, addr_q} < DEPTH_LIM;
    assign mem_idx  = addr_q[AW-1:0];
    assign rd_data  = in_range ? mem[mem_idx] : 16'h0000;

    // Rotating search: first requester strictly after the last grant, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found    = 1'b0;
        pick     = last_q;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_CORES) cand = cand - NUM_CORES;
            cand_idx = GW'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
    end

    always_comb begin
        sel_addr = 16'h0000;
        sel_data = 16'h0000;
        sel_wr   = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick == GW'(i)) begin
                sel_addr = DMADDR[16*i +: 16];
                sel_data = DOUT[16*i +: 16];
                sel_wr   = MEMWR[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        din_d   = din_q;
        rdy_d   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    last_d  = pick;
                    addr_d  = sel_addr;
                    wdata_d = sel_data;
                    wr_d    = sel_wr;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (grant_q == GW'(i)) begin
                        rdy_d[i] = 1'b1;
                        if (!wr_q) din_d[16*i +: 16] = rd_data;
                    end
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            din_q   <= '0;
            rdy_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
            rdy_q   <= rdy_d;
        end
    end

    // NOTE: the RAM array has no reset; clearing it would prevent block-RAM mapping, so only the write enable sees rst.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ACCESS && wr_q && in_range) begin
            mem[mem_idx] <= wdata_q;
        end
    end

    assign DIN    = din_q;
    assign MEMRDY = rdy_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios plus randomized multi-core traffic
// compared each cycle against a transaction-level timing/memory model.
module tb_data_memory_responder;

    localparam int NC    = 2;
    localparam int DEPTH = 256;

    logic                clk = 1'b0;
    logic                rst;
    logic [NC-1:0]       memread, memwr;
    logic [16*NC-1:0]    dmaddr, dout;
    logic [16*NC-1:0]    din;
    logic [NC-1:0]       memrdy;

    data_memory_responder #(.NUM_CORES(NC), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .MEMREAD(memread),
        .MEMWR  (memwr),
        .DMADDR (dmaddr),
        .DOUT   (dout),
        .DIN    (din),
        .MEMRDY (memrdy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Per-core request registers driven onto the DUT ports.
    bit          c_rd   [NC];
    bit          c_wr   [NC];
    logic [15:0] c_addr [NC];
    logic [15:0] c_data [NC];
    logic [NC-1:0] seen;

    task automatic apply();
        for (int i = 0; i < NC; i++) begin
            memread[i]          = c_rd[i];
            memwr[i]            = c_wr[i];
            dmaddr[16*i +: 16]  = c_addr[i];
            dout[16*i +: 16]    = c_data[i];
        end
    endtask

    // Reference model: a granted access completes one edge after the grant; the arbiter is
    // free to sample again three edges after a grant, or one edge after reset.
    logic [15:0]   m_mem [DEPTH];
    logic [15:0]   m_din [NC];
    logic [NC-1:0] m_rdy;
    int            m_last, edge_n, next_free, done_at, m_g;
    bit            m_wr;
    logic [15:0]   m_addr, m_wdata;

    task automatic model_edge();
        m_rdy = '0;
        if (rst) begin
            m_last    = NC - 1;
            for (int i = 0; i < NC; i++) m_din[i] = 16'h0000;
            done_at   = -1;
            next_free = edge_n + 1;
            edge_n++;
            return;
        end
        if (done_at == edge_n) begin
            if (m_wr) begin
                if (int'(m_addr) < DEPTH) m_mem[int'(m_addr)] = m_wdata;
            end else begin
                m_din[m_g] = (int'(m_addr) < DEPTH) ? m_mem[int'(m_addr)] : 16'h0000;
            end
            m_rdy[m_g] = 1'b1;
        end
        if (edge_n >= next_free) begin
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (m_last + k) % NC;
                if (c_rd[c] || c_wr[c]) begin
                    m_g       = c;
                    m_last    = c;
                    m_wr      = c_wr[c];
                    m_addr    = c_addr[c];
                    m_wdata   = c_data[c];
                    done_at   = edge_n + 1;
                    next_free = edge_n + 3;
                    break;
                end
            end
        end
        edge_n++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("rdy", 32'(memrdy), 32'(m_rdy));
        for (int i = 0; i < NC; i++)
            check($sformatf("din%0d", i), 32'(din[16*i +: 16]), 32'(m_din[i]));
        seen = memrdy;
    endtask

    function automatic logic [15:0] din_of(input int core);
        return din[16*core +: 16];
    endfunction

    // Single transaction from an otherwise idle system; expects MEMRDY two edges after sampling.
    task automatic do_txn(input int core, input bit rd, input bit wr,
                          input logic [15:0] addr, input logic [15:0] data);
        int lat;
        bit got;
        c_rd[core] = rd; c_wr[core] = wr; c_addr[core] = addr; c_data[core] = data;
        apply();
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            step();
            lat++;
            if (seen[core]) got = 1'b1;
        end
        check($sformatf("lat_core%0d_addr%h", core, addr), 32'(lat), 32'd2);
        c_rd[core] = 1'b0; c_wr[core] = 1'b0;
        apply();
        step();
    endtask

    function automatic logic [15:0] preload_val(input int a);
        if (a == 1) return 16'h1111;
        if (a == 2) return 16'h2222;
        return 16'hC000 + 16'(a);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] din0_before;
        bit          busy [NC];
        int          pulses;
        int          pulse_j [4];
        logic [NC-1:0] pulse_v [4];

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
        for (int i = 0; i < NC; i++) begin
            m_din[i] = 16'h0000;
            c_rd[i] = 1'b0; c_wr[i] = 1'b0; c_addr[i] = 16'h0; c_data[i] = 16'h0;
            busy[i] = 1'b0;
        end
        m_last = NC - 1; edge_n = 0; next_free = 0; done_at = -1; m_g = 0;
        m_wr = 1'b0; m_addr = 16'h0; m_wdata = 16'h0; m_rdy = '0; seen = '0;
        apply();

        // Reset state.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_memrdy", 32'(memrdy), 32'd0);
        check("reset_din", din, 32'd0);

        // Preload addresses 0..31 through core 0.
        for (int a = 0; a < 32; a++) do_txn(0, 1'b0, 1'b1, 16'(a), preload_val(a));

        // Write then read back on core 0.
        do_txn(0, 1'b0, 1'b1, 16'd5, 16'hBEEF);
        do_txn(0, 1'b1, 1'b0, 16'd5, 16'h0);
        check("beef_din0", 32'(din_of(0)), 32'h0000BEEF);
        check("beef_din1", 32'(din_of(1)), 32'h00000000);

        // Out-of-range write/read on core 1; low address bits must not alias onto mem[0].
        do_txn(1, 1'b0, 1'b1, 16'(DEPTH), 16'h1234);
        do_txn(1, 1'b1, 1'b0, 16'(DEPTH), 16'h0);
        check("oor_din1", 32'(din_of(1)), 32'h00000000);
        do_txn(0, 1'b1, 1'b0, 16'd0, 16'h0);
        check("oor_mem0", 32'(din_of(0)), 32'h0000C000);

        // Read and write together act as a write only.
        din0_before = din_of(0);
        do_txn(0, 1'b1, 1'b1, 16'd3, 16'hA5A5);
        check("both_din0_kept", 32'(din_of(0)), 32'(din0_before));
        do_txn(1, 1'b1, 1'b0, 16'd3, 16'h0);
        check("both_mem3", 32'(din_of(1)), 32'h0000A5A5);

        // Write by core 1 then read of the same address by core 0.
        do_txn(1, 1'b0, 1'b1, 16'd7, 16'h5A5A);
        do_txn(0, 1'b1, 1'b0, 16'd7, 16'h0);
        check("raw_din0", 32'(din_of(0)), 32'h00005A5A);

        // Contention from reset: both cores read continuously.
        rst = 1'b1;
        step();
        rst = 1'b0;
        c_rd[0] = 1'b1; c_addr[0] = 16'd1;
        c_rd[1] = 1'b1; c_addr[1] = 16'd2;
        apply();
        pulses = 0;
        for (int j = 1; j <= 12; j++) begin
            step();
            if (seen != '0) begin
                if (pulses < 4) begin
                    pulse_j[pulses] = j;
                    pulse_v[pulses] = seen;
                end
                pulses++;
            end
        end
        check("rr_pulse_count", 32'(pulses), 32'd4);
        for (int p = 0; p < 4; p++) begin
            if (p < pulses) begin
                check($sformatf("rr_pulse%0d_cycle", p), 32'(pulse_j[p]), 32'(2 + 3 * p));
                check($sformatf("rr_pulse%0d_core", p), 32'(pulse_v[p]), (p % 2 == 0) ? 32'd1 : 32'd2);
            end
        end
        c_rd[0] = 1'b0; c_rd[1] = 1'b0;
        apply();
        step();
        step();
        check("rr_din0", 32'(din_of(0)), 32'h00001111);
        check("rr_din1", 32'(din_of(1)), 32'h00002222);

        // Reset landing on the access cycle of a write.
        c_wr[0] = 1'b1; c_addr[0] = 16'd9; c_data[0] = 16'h7777;
        apply();
        step();
        rst = 1'b1;
        c_wr[0] = 1'b0;
        apply();
        step();
        check("rstacc_memrdy", 32'(memrdy), 32'd0);
        check("rstacc_din", din, 32'd0);
        rst = 1'b0;
        c_rd[0] = 1'b1; c_addr[0] = 16'd9;
        c_rd[1] = 1'b1; c_addr[1] = 16'd9;
        apply();
        pulses = 0;
        for (int j = 1; j <= 6; j++) begin
            step();
            if (seen != '0) begin
                if (pulses < 2) begin
                    pulse_j[pulses] = j;
                    pulse_v[pulses] = seen;
                end
                pulses++;
                if (seen[0]) c_rd[0] = 1'b0;
                if (seen[1]) c_rd[1] = 1'b0;
                apply();
            end
        end
        check("rstacc_pulses", 32'(pulses), 32'd2);
        check("rstacc_first_core", 32'(pulse_v[0]), 32'd1);
        check("rstacc_first_cycle", 32'(pulse_j[0]), 32'd2);
        check("rstacc_mem9_din0", 32'(din_of(0)), 32'h0000C009);
        check("rstacc_mem9_din1", 32'(din_of(1)), 32'h0000C009);
        step();

        // Randomized traffic from all cores, with occasional resets.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < NC; i++) begin
                if (busy[i] && seen[i]) busy[i] = 1'b0;
                if (!busy[i]) begin
                    c_rd[i] = 1'b0; c_wr[i] = 1'b0;
                    if ($urandom_range(0, 2) == 0) begin
                        int r;
                        r = int'($urandom_range(0, 3));
                        c_rd[i] = (r <= 1) || (r == 3);
                        c_wr[i] = (r >= 2);
                        if ($urandom_range(0, 7) == 0) begin
                            r = int'($urandom_range(0, 2));
                            c_addr[i] = (r == 0) ? 16'(DEPTH) : (r == 1) ? 16'(DEPTH + 1) : 16'hFFFF;
                        end else begin
                            c_addr[i] = 16'($urandom_range(0, 31));
                        end
                        c_data[i] = 16'($urandom);
                        busy[i] = 1'b1;
                    end
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            apply();
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Shared data-memory responder serving the data-side load/store interface of NUM_CORES cores (the DMADDR/DOUT/MEMREAD/MEMWR/DIN port set each core drives). It holds a word-addressed data RAM, arbitrates round-robin among requesting cores, performs one access at a time, and returns read data plus a one-cycle completion pulse to the granted core. It sits beside the per-core instruction memories in the multicore processor top level.

## Interface
- NUM_CORES, 2: number of attached cores (1–8).
- DEPTH, 256: data RAM depth in 16-bit words.
- clk  in  1: system clock; all logic on rising edge.
- rst  in  1: synchronous, active-high reset.
- MEMREAD  in  NUM_CORES: per-core read request, bit i = core i.
- MEMWR  in  NUM_CORES: per-core write request.
- DMADDR  in  16*NUM_CORES: per-core word address, core i at [16i+15:16i].
- DOUT  in  16*NUM_CORES: per-core write data, same slicing.
- DIN  out  16*NUM_CORES: per-core read data, same slicing, registered.
- MEMRDY  out  NUM_CORES: per-core completion pulse, registered.

## Operation
- Request of core i: req[i] = MEMREAD[i] | MEMWR[i]. The core holds MEMREAD/MEMWR/DMADDR/DOUT stable until it samples MEMRDY[i]=1.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any req, grant g = first requesting core searching upward (with wrap) from last+1; latch g, address, write data, op; update last = g; go ACCESS. No req: stay IDLE.
  - ACCESS: perform the operation; set MEMRDY[g]=1; go RESP.
  - RESP: clear MEMRDY; go IDLE.
- Write (MEMWR[g]=1): mem[addr] <= write data; DIN[g] unchanged.
- Read (MEMREAD[g]=1, MEMWR[g]=0): DIN[g] <= mem[addr]; other DIN slices unchanged.
- MEMREAD and MEMWR both high: treated as write only; DIN[g] unchanged.
- Address ≥ DEPTH: write discarded; read returns 16'h0000; MEMRDY still pulses.
- Only address bits [clog2(DEPTH)-1:0] index the RAM after the range check; no wrap-around aliasing.
- Requests from non-granted cores wait; no request is dropped while held.
- Round-robin: after reset, last = NUM_CORES-1, so core 0 has first priority.

## Timing
- Reset values: state IDLE, MEMRDY = 0, every DIN slice = 16'h0000, last = NUM_CORES-1. RAM contents are not cleared.
- Request stable before edge E0 (state IDLE) → grant latched at E0.
- At E1, the write is committed or DIN[g] is loaded, and MEMRDY[g] rises. It is high for exactly one cycle (E1–E2).
- At E2, the core samples MEMRDY and may change or drop the request. The FSM is in IDLE and samples new requests at E3.
- Fixed latency: 2 cycles from the sampling edge to MEMRDY. Peak throughput: one access per 3 cycles.
- A write at E1 is visible to a read granted at E3 or later.
- Input changes during ACCESS/RESP have no effect, because operands were latched at E0.
- rst has priority in every state. If rst is high at E1, the pending write is not performed and no MEMRDY is issued. The core must re-issue after reset.
- Only one MEMRDY bit is ever high at a time.

## Test plan
- Core 0 writes 16'hBEEF to addr 5, then reads addr 5 → MEMRDY[0] pulses 2 cycles after each request is sampled; after the read, DIN[0] = 16'hBEEF and DIN[1] stays 0.
- Cores 0 and 1 both request continuously from reset (reads of addrs 1 and 2, preloaded 16'h1111/16'h2222) → grants alternate 0,1,0,1. MEMRDY pulses are 3 cycles apart, and DIN[0]=16'h1111, DIN[1]=16'h2222.
- Core 1 writes 16'h1234 to addr DEPTH, then reads addr DEPTH → MEMRDY pulses both times; DIN[1]=16'h0000; mem[0] is unchanged.
- Core 0 asserts MEMREAD and MEMWR together with addr 3 and data 16'hA5A5 → mem[3]=16'hA5A5 and DIN[0] keeps its prior value.
- rst asserted on the ACCESS cycle of a write of 16'h7777 to addr 9 → no MEMRDY, mem[9] unchanged, all outputs 0, and the next grant goes to core 0.
- Read immediately following a write to the same address by a different core → the read returns the new data.
